// File: rtl/jt1943_sched_pkg.sv
// jt1943_sched_pkg
// Shared types, default sizing and the round-robin search helper used by the
// ROM request scheduler (jt1943_rom_sched) and its arbiter (jt1943_rr_arb).
//   state_t   : scheduler FSM states
//   DEF_*     : default parameter values for the scheduler
//   rr_pick() : first set bit of mask searching upward from ptr+1, wrapping
package jt1943_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        REFRESH = 2'd2
    } state_t;

    localparam int DEF_SLOTS      = 4;
    localparam int DEF_AW         = 22;
    localparam int DEF_DW         = 32;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_REF_PERIOD = 180;
    localparam int DEF_REF_BUSY   = 3;
    localparam int MAX_SLOTS      = 8;

    // Unused upper mask bits must be zero: the 8-way wrap then visits exactly
    // the same order as a wrap modulo the real slot count.
    // Returns ptr when the mask is empty.
    function automatic logic [2:0] rr_pick(input logic [MAX_SLOTS-1:0] mask,
                                           input logic [2:0]           ptr);
        logic [2:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= MAX_SLOTS; k++) begin
            idx = ptr + 3'(k);
            if (!found && mask[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/jt1943_rom_sched_if.sv
// jt1943_rom_sched_if
// Bundles the ROM client side and the SDRAM read port of the scheduler.
//   slot_req/slot_addr : per-slot request level and word address (clients)
//   slot_ok/slot_dout  : per-slot hit flag and cached data (scheduler)
//   sdram_re/addr      : toggle read strobe and latched address (scheduler)
//   data_read          : fixed-latency SDRAM read data (SDRAM)
// slave modport = scheduler, master modport = clients + SDRAM model.
interface jt1943_rom_sched_if
    import jt1943_sched_pkg::*;
#(
    parameter int SLOTS = DEF_SLOTS,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
);
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_re;
    logic [AW-1:0]       sdram_addr;
    logic [DW-1:0]       data_read;

    modport slave (
        input  slot_req, slot_addr, data_read,
        output slot_ok, slot_dout, sdram_re, sdram_addr
    );

    modport master (
        output slot_req, slot_addr, data_read,
        input  slot_ok, slot_dout, sdram_re, sdram_addr
    );
endinterface

// File: rtl/jt1943_rr_arb.sv
// jt1943_rr_arb
// Combinational round-robin picker. The pointer register lives in the parent
// so the parent decides when a pick actually becomes a grant.
//   i_req   : request mask (SLOTS bits)
//   i_ptr   : index of the last grant; search starts at i_ptr+1
//   o_any   : at least one request present
//   o_grant : index of the chosen request (valid when o_any)
module jt1943_rr_arb
    import jt1943_sched_pkg::*;
#(
    parameter  int SLOTS = DEF_SLOTS,
    localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic [SLOTS-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic             o_any,
    output logic [PW-1:0]    o_grant
);
    logic [MAX_SLOTS-1:0] w_mask;

    assign w_mask  = MAX_SLOTS'(i_req);
    assign o_grant = PW'(rr_pick(w_mask, 3'(i_ptr)));
    assign o_any   = |i_req;
endmodule

// File: rtl/jt1943_rom_sched.sv
// jt1943_rom_sched
// Shares one SDRAM read port between SLOTS ROM clients. Each slot keeps a
// one-entry cache (address + data); misses are served round-robin, one read
// at a time. Also schedules autorefresh and blocks the port during download.
//   clk, rst_n  : clock, asynchronous active-low reset
//   downloading : ROM download in progress (flushes caches, blocks reads)
//   bus         : client requests/data and SDRAM read port (slave modport)
//   autorefresh : one-cycle refresh request pulse
//   loop_rst    : SDRAM loop reset, follows downloading one cycle later
module jt1943_rom_sched
    import jt1943_sched_pkg::*;
#(
    parameter int SLOTS      = DEF_SLOTS,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int REF_PERIOD = DEF_REF_PERIOD,
    parameter int REF_BUSY   = DEF_REF_BUSY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    jt1943_rom_sched_if.slave bus,
    output logic              autorefresh,
    output logic              loop_rst
);
    localparam int PW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int RW   = $clog2(REF_PERIOD);
    localparam int CMAX = (LATENCY > REF_BUSY) ? LATENCY : REF_BUSY;
    localparam int CW   = $clog2(CMAX + 1);

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [RW-1:0]    r_ref_cnt;
    logic             r_pend, w_wrap;
    logic [PW-1:0]    r_ptr, r_grant, w_pick;
    logic             w_any, w_start, w_fill, w_ref_start;
    logic             r_re, r_autoref, r_loop_rst;
    logic [AW-1:0]    r_addr;
    logic [SLOTS-1:0] r_valid, w_hit, w_miss;
    logic [AW-1:0]    r_cache_addr [SLOTS];
    logic [DW-1:0]    r_dout       [SLOTS];
    logic [AW-1:0]    w_req_addr   [SLOTS];

    // A slot whose address moved while its read was in flight compares
    // against the stale cached address here and simply misses again.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign w_req_addr[gi] = bus.slot_addr[gi*AW +: AW];
            assign w_hit[gi]  = bus.slot_req[gi] & r_valid[gi] &
                                (r_cache_addr[gi] == w_req_addr[gi]);
            assign w_miss[gi] = bus.slot_req[gi] & ~w_hit[gi];
            assign bus.slot_dout[gi*DW +: DW] = r_dout[gi];
        end
    endgenerate

    assign bus.slot_ok    = w_hit;
    assign bus.sdram_re   = r_re;
    assign bus.sdram_addr = r_addr;
    assign autorefresh    = r_autoref;
    assign loop_rst       = r_loop_rst;

    jt1943_rr_arb #(.SLOTS(SLOTS)) u_arb (
        .i_req   (w_miss),
        .i_ptr   (r_ptr),
        .o_any   (w_any),
        .o_grant (w_pick)
    );

    assign w_wrap = (r_ref_cnt == RW'(REF_PERIOD - 1));

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        w_fill       = 1'b0;
        w_ref_start  = 1'b0;
        case (r_state)
            IDLE: begin
                // Refresh wins over misses so it can never be starved.
                if (r_pend) begin
                    w_ref_start  = 1'b1;
                    w_state_next = REFRESH;
                    w_cnt_next   = CW'(REF_BUSY - 1);
                end else if (w_any) begin
                    w_start      = 1'b1;
                    w_state_next = WAIT;
                    w_cnt_next   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            REFRESH: begin
                if (r_cnt == '0) w_state_next = IDLE;
                else             w_cnt_next   = r_cnt - CW'(1);
            end
            default: w_state_next = IDLE;
        endcase
        // Download aborts whatever is in flight; its read data is dropped.
        if (downloading) begin
            w_state_next = IDLE;
            w_start      = 1'b0;
            w_fill       = 1'b0;
            w_ref_start  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ref_cnt  <= '0;
            r_pend     <= 1'b0;
            r_ptr      <= PW'(SLOTS - 1);
            r_grant    <= '0;
            r_re       <= 1'b0;
            r_addr     <= '0;
            r_autoref  <= 1'b0;
            r_loop_rst <= 1'b1;
            r_valid    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_cache_addr[i] <= '0;
                r_dout[i]       <= '0;
            end
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_autoref  <= w_ref_start;
            r_loop_rst <= downloading;
            if (downloading) begin
                r_ref_cnt <= '0;
                r_pend    <= 1'b0;
                r_valid   <= '0;
            end else begin
                r_ref_cnt <= w_wrap ? '0 : r_ref_cnt + RW'(1);
                // A wrap while one is still pending merges into it.
                r_pend    <= w_wrap | (r_pend & ~w_ref_start);
            end
            if (w_start) begin
                r_ptr   <= w_pick;
                r_grant <= w_pick;
                r_addr  <= w_req_addr[w_pick];
                r_re    <= ~r_re;
            end
            // Fill even if the requester dropped its request meanwhile.
            if (w_fill) begin
                r_dout[r_grant]       <= bus.data_read;
                r_cache_addr[r_grant] <= r_addr;
                r_valid[r_grant]      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jt1943_rom_sched.sv
// tb_jt1943_rom_sched
// Directed bench for jt1943_rom_sched with default parameters
// (SLOTS=4, AW=22, DW=32, LATENCY=4, REF_PERIOD=180, REF_BUSY=3).
// Cycle k is the window just after the k-th rising edge following reset
// release; inputs are driven and outputs sampled 1 time unit after the edge.
module tb_jt1943_rom_sched;
    logic clk = 1'b0;
    logic rst_n;
    logic downloading;
    logic autorefresh;
    logic loop_rst;
    int   n_cmp = 0;
    int   n_err = 0;

    jt1943_rom_sched_if #(.SLOTS(4), .AW(22), .DW(32)) bus_if ();

    jt1943_rom_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .bus         (bus_if),
        .autorefresh (autorefresh),
        .loop_rst    (loop_rst)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int slot, input logic [21:0] a);
        bus_if.slot_addr[slot*22 +: 22] = a;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        downloading        = 1'b0;
        bus_if.slot_req    = '0;
        bus_if.slot_addr   = '0;
        bus_if.data_read   = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic prev_re;
        int   toggles;
        int   pulses;
        int   pulse_cyc;

        // ---------------- reset values ----------------
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_sdram_re", bus_if.sdram_re, 1'b0);
        chk("rst_sdram_addr", bus_if.sdram_addr, 22'h0);
        chk("rst_autorefresh", autorefresh, 1'b0);
        chk("rst_loop_rst", loop_rst, 1'b1);
        chk("rst_slot_ok", bus_if.slot_ok, 4'h0);
        chk("rst_slot_dout", bus_if.slot_dout, 128'h0);

        // ---------------- slot0 single miss ----------------
        do_reset();
        bus_if.slot_req[0] = 1'b1;
        set_addr(0, 22'h000123);
        bus_if.data_read = 32'h1111_1111;
        tick(); // cycle 1
        chk("miss_re_c1", bus_if.sdram_re, 1'b1);
        chk("miss_addr_c1", bus_if.sdram_addr, 22'h000123);
        tick(); tick(); tick(); // cycle 4
        chk("miss_ok_c4", bus_if.slot_ok, 4'h0);
        bus_if.data_read = 32'hDEAD_BEEF;
        tick(); // cycle 5
        bus_if.data_read = 32'h1111_1111;
        chk("miss_ok_c5", bus_if.slot_ok, 4'h1);
        chk("miss_dout0", bus_if.slot_dout[31:0], 32'hDEAD_BEEF);
        chk("miss_re_once", bus_if.sdram_re, 1'b1);

        // ---------------- repeat hit after drop/raise ----------------
        bus_if.slot_req[0] = 1'b0;
        tick(); // cycle 6
        chk("hit_dropped_ok", bus_if.slot_ok, 4'h0);
        bus_if.slot_req[0] = 1'b1;
        #1;
        chk("hit_same_cycle", bus_if.slot_ok, 4'h1);
        chk("hit_dout0", bus_if.slot_dout[31:0], 32'hDEAD_BEEF);
        tick(); tick();
        chk("hit_no_toggle", bus_if.sdram_re, 1'b1);
        chk("hit_addr_kept", bus_if.sdram_addr, 22'h000123);

        // ---------------- 4 simultaneous misses ----------------
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 22'h100 + 22'(i));
        bus_if.slot_req  = 4'hF;
        bus_if.data_read = 32'hC0DE_0000;
        prev_re = 1'b0;
        toggles = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus_if.data_read = 32'hC0DE_0000 + 32'(c);
            if (bus_if.sdram_re !== prev_re) toggles++;
            prev_re = bus_if.sdram_re;
            if (c % 5 == 1)
                chk($sformatf("rr_grant%0d_addr", c / 5), bus_if.sdram_addr, 22'h100 + 22'(c / 5));
            if (c == 5)
                chk("rr_ok_c5", bus_if.slot_ok, 4'h1);
        end
        chk("rr_toggles", 32'(toggles), 32'd4);
        chk("rr_ok_all", bus_if.slot_ok, 4'hF);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_dout%0d", i), bus_if.slot_dout[i*32 +: 32], 32'hC0DE_0000 + 32'(5*i + 4));

        // ---------------- refresh: 200 idle cycles ----------------
        do_reset();
        pulses    = 0;
        pulse_cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (autorefresh === 1'b1) begin
                pulses++;
                pulse_cyc = c;
            end
        end
        chk("ref_pulse_count", 32'(pulses), 32'd1);
        // counter wraps at edge 180 (pending), pulse registers at edge 181
        chk("ref_pulse_cycle", 32'(pulse_cyc), 32'd181);

        // ---------------- refresh delays a coincident miss ----------------
        do_reset();
        repeat (180) tick(); // cycle 180: pending just set
        bus_if.slot_req[1] = 1'b1;
        set_addr(1, 22'h000055);
        tick(); // 181
        chk("refmiss_pulse", autorefresh, 1'b1);
        chk("refmiss_re_c181", bus_if.sdram_re, 1'b0);
        tick(); tick(); tick(); // 184
        chk("refmiss_re_c184", bus_if.sdram_re, 1'b0);
        tick(); // 185
        chk("refmiss_re_c185", bus_if.sdram_re, 1'b1);
        chk("refmiss_addr", bus_if.sdram_addr, 22'h000055);

        // ---------------- download aborts WAIT ----------------
        do_reset();
        bus_if.slot_req[2] = 1'b1;
        set_addr(2, 22'h000222);
        for (int c = 1; c <= 11; c++) begin
            tick();
            bus_if.data_read = (c == 10) ? 32'h2222_AAAA : 32'hBAD0_0000 + 32'(c);
            if (c == 1) chk("dl_re_c1", bus_if.sdram_re, 1'b1);
            if (c == 2) downloading = 1'b1;
            if (c == 6) begin
                chk("dl_ok_zero", bus_if.slot_ok, 4'h0);
                chk("dl_loop_rst", loop_rst, 1'b1);
                chk("dl_no_toggle", bus_if.sdram_re, 1'b1);
                chk("dl_no_fill", bus_if.slot_dout[95:64], 32'h0);
                downloading = 1'b0;
            end
            if (c == 7) begin
                chk("dl_loop_rst_fall", loop_rst, 1'b0);
                chk("dl_retoggle", bus_if.sdram_re, 1'b0);
                chk("dl_readdr", bus_if.sdram_addr, 22'h000222);
            end
        end
        chk("dl_refill_ok", bus_if.slot_ok, 4'h4);
        chk("dl_refill_dout", bus_if.slot_dout[95:64], 32'h2222_AAAA);

        // ---------------- async reset mid-WAIT ----------------
        do_reset();
        bus_if.slot_req[0] = 1'b1;
        set_addr(0, 22'h000333);
        tick(); // 1
        chk("ar_re_c1", bus_if.sdram_re, 1'b1);
        tick(); // 2, in WAIT
        rst_n = 1'b0;
        #1;
        chk("ar_re_async", bus_if.sdram_re, 1'b0);
        chk("ar_addr_async", bus_if.sdram_addr, 22'h0);
        chk("ar_loop_rst_async", loop_rst, 1'b1);
        chk("ar_ok_async", bus_if.slot_ok, 4'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); // 1 after release
        chk("ar_re_after", bus_if.sdram_re, 1'b1);
        chk("ar_addr_after", bus_if.sdram_addr, 22'h000333);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
